// File: rtl/accumulator_bank.sv
// accumulator_bank: NACC signed accumulators with LOAD/ADD/SUB/CLR, saturating
// arithmetic, sticky per-accumulator overflow flags and one combinational read port.
module accumulator_bank #(
  parameter int unsigned DW         = 16,
  parameter int unsigned IW         = 8,
  parameter int unsigned NACC       = 4,
  parameter bit          IMM_SIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    loadacc,
  input  logic [1:0]              selacc,
  input  logic [1:0]              mode,
  input  logic [$clog2(NACC)-1:0] wr_sel,
  input  logic [IW-1:0]           immediate,
  input  logic [DW-1:0]           rd_data,
  input  logic [DW-1:0]           res_out,
  input  logic [$clog2(NACC)-1:0] rd_sel,
  output logic [DW-1:0]           acc_data,
  output logic                    acc_zero,
  output logic                    acc_neg,
  output logic                    acc_ovf,
  output logic                    op_done
);

  localparam int unsigned AW = $clog2(NACC);

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]   acc_q [NACC];
  logic [NACC-1:0] ovf_q;

  logic [DW-1:0] imm_ext;
  logic [DW-1:0] src;
  logic [DW-1:0] acc_cur;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] sat_val;
  logic          add_ovf;
  logic          sub_ovf;
  logic [DW-1:0] acc_nxt;
  logic          ovf_nxt;
  logic [AW-1:0] wr_idx;

  assign wr_idx = wr_sel;

  // Immediate widening: sign- or zero-extension chosen at elaboration.
  if (IMM_SIGNED) begin : g_sext
    assign imm_ext = DW'($signed(immediate));
  end else begin : g_zext
    assign imm_ext = DW'(immediate);
  end

  // Operand source mux.
  always_comb begin
    src = res_out;
    case (selacc)
      2'b00:   src = imm_ext;
      2'b01:   src = rd_data;
      default: src = res_out;
    endcase
  end

  // Next value of the targeted accumulator; overflow judged from operand/result sign bits.
  always_comb begin
    acc_cur = acc_q[wr_idx];
    sum     = acc_cur + src;
    diff    = acc_cur - src;
    add_ovf = (acc_cur[DW-1] == src[DW-1]) && (sum[DW-1]  != acc_cur[DW-1]);
    sub_ovf = (acc_cur[DW-1] != src[DW-1]) && (diff[DW-1] != acc_cur[DW-1]);
    sat_val = acc_cur[DW-1] ? SAT_MIN : SAT_MAX;
    acc_nxt = acc_cur;
    ovf_nxt = ovf_q[wr_idx];
    case (mode)
      MODE_LOAD: begin
        acc_nxt = src;
        ovf_nxt = 1'b0;
      end
      MODE_ADD: begin
        acc_nxt = add_ovf ? sat_val : sum;
        if (add_ovf) ovf_nxt = 1'b1;
      end
      MODE_SUB: begin
        acc_nxt = sub_ovf ? sat_val : diff;
        if (sub_ovf) ovf_nxt = 1'b1;
      end
      MODE_CLR: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      default: begin
        acc_nxt = acc_cur;
      end
    endcase
  end

  // Accumulator/flag storage; reset wins over any operation in the same cycle.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < int'(NACC); i++) acc_q[i] <= '0;
      ovf_q   <= '0;
      op_done <= 1'b0;
    end else begin
      op_done <= loadacc;
      if (loadacc) begin
        acc_q[wr_idx] <= acc_nxt;
        ovf_q[wr_idx] <= ovf_nxt;
      end
    end
  end

  // Read port reflects stored state only; no bypass of an in-flight write.
  always_comb begin
    acc_data = acc_q[rd_sel];
    acc_zero = (acc_data == '0);
    acc_neg  = acc_data[DW-1];
    acc_ovf  = ovf_q[rd_sel];
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank (DW=16, IW=8, NACC=4, signed immediate).
module tb_accumulator_bank;

  localparam logic [1:0] M_LOAD = 2'b00;
  localparam logic [1:0] M_ADD  = 2'b01;
  localparam logic [1:0] M_SUB  = 2'b10;
  localparam logic [1:0] M_CLR  = 2'b11;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        loadacc;
  logic [1:0]  selacc;
  logic [1:0]  mode;
  logic [1:0]  wr_sel;
  logic [7:0]  immediate;
  logic [15:0] rd_data;
  logic [15:0] res_out;
  logic [1:0]  rd_sel;
  logic [15:0] acc_data;
  logic        acc_zero;
  logic        acc_neg;
  logic        acc_ovf;
  logic        op_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mdl_acc [4];
  logic        mdl_ovf [4];
  exp_t        sb [$];

  accumulator_bank #(.DW(16), .IW(8), .NACC(4), .IMM_SIGNED(1'b1)) dut (
    .clk(clk), .rstn(rstn), .loadacc(loadacc), .selacc(selacc), .mode(mode),
    .wr_sel(wr_sel), .immediate(immediate), .rd_data(rd_data), .res_out(res_out),
    .rd_sel(rd_sel), .acc_data(acc_data), .acc_zero(acc_zero), .acc_neg(acc_neg),
    .acc_ovf(acc_ovf), .op_done(op_done)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic with explicit clamping.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mdl_acc[i] = '0;
      mdl_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [1:0] m, input logic [1:0] s, input logic [1:0] w,
                             input logic [7:0] imm, input logic [15:0] rd, input logic [15:0] res);
    logic [15:0] src;
    int a, b, r;
    if (s == 2'b00)      src = {{8{imm[7]}}, imm};
    else if (s == 2'b01) src = rd;
    else                 src = res;
    a = $signed(mdl_acc[w]);
    b = $signed(src);
    case (m)
      M_LOAD: begin mdl_acc[w] = src; mdl_ovf[w] = 1'b0; end
      M_CLR:  begin mdl_acc[w] = '0;  mdl_ovf[w] = 1'b0; end
      default: begin
        r = (m == M_ADD) ? a + b : a - b;
        if (r > 32767)       begin r = 32767;  mdl_ovf[w] = 1'b1; end
        else if (r < -32768) begin r = -32768; mdl_ovf[w] = 1'b1; end
        mdl_acc[w] = 16'(r);
      end
    endcase
  endtask

  // One accepted operation; result checked after the accepting edge.
  task automatic issue(input logic [1:0] m, input logic [1:0] s, input logic [1:0] w,
                       input logic [7:0] imm, input logic [15:0] rd, input logic [15:0] res);
    exp_t e;
    @(negedge clk);
    loadacc = 1'b1; mode = m; selacc = s; wr_sel = w;
    immediate = imm; rd_data = rd; res_out = res; rd_sel = w;
    model_apply(m, s, w, imm, rd, res);
    e.idx = w; e.acc = mdl_acc[w]; e.ovf = mdl_ovf[w];
    sb.push_back(e);
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL scoreboard_empty got=0 entries want>=1");
    end else begin
      e = sb.pop_front();
      checks++;
      if (op_done !== 1'b1) begin failures++; $display("FAIL op_done got=%b want=1", op_done); end
      checks++;
      if (acc_data !== e.acc) begin failures++; $display("FAIL acc%0d_data got=%h want=%h", e.idx, acc_data, e.acc); end
      checks++;
      if (acc_ovf !== e.ovf) begin failures++; $display("FAIL acc%0d_ovf got=%b want=%b", e.idx, acc_ovf, e.ovf); end
      checks++;
      if (acc_zero !== (e.acc == 16'h0)) begin failures++; $display("FAIL acc%0d_zero got=%b want=%b", e.idx, acc_zero, e.acc == 16'h0); end
      checks++;
      if (acc_neg !== e.acc[15]) begin failures++; $display("FAIL acc%0d_neg got=%b want=%b", e.idx, acc_neg, e.acc[15]); end
    end
  endtask

  // Idle cycles: nothing changes, op_done stays low.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      loadacc = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (op_done !== 1'b0) begin failures++; $display("FAIL idle_op_done got=%b want=0", op_done); end
      checks++;
      if (acc_data !== mdl_acc[rd_sel]) begin failures++; $display("FAIL idle_hold acc%0d got=%h want=%h", rd_sel, acc_data, mdl_acc[rd_sel]); end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; loadacc = 1'b0; mode = M_LOAD; selacc = 2'b00; wr_sel = '0;
    immediate = '0; rd_data = '0; res_out = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (acc_data !== 16'h0) begin failures++; $display("FAIL reset_acc%0d got=%h want=0000", i, acc_data); end
      checks++;
      if ({acc_zero, acc_neg, acc_ovf} !== 3'b100) begin failures++; $display("FAIL reset_flags%0d got=%b want=100", i, {acc_zero, acc_neg, acc_ovf}); end
    end
    checks++;
    if (op_done !== 1'b0) begin failures++; $display("FAIL reset_op_done got=%b want=0", op_done); end
  endtask

  task automatic test_load_imm();
    issue(M_LOAD, 2'b00, 2'd1, 8'h80, 16'h0, 16'h0);
    checks++;
    if (acc_data !== 16'hFF80 || acc_neg !== 1'b1) begin
      failures++; $display("FAIL load_imm_sext got=%h/%b want=ff80/1", acc_data, acc_neg);
    end
    idle(1);
  endtask

  task automatic test_sat_pos();
    issue(M_LOAD, 2'b01, 2'd2, 8'h00, 16'h7FF0, 16'h0);
    issue(M_ADD,  2'b01, 2'd2, 8'h00, 16'h0020, 16'h0);
    checks++;
    if (acc_data !== 16'h7FFF || acc_ovf !== 1'b1) begin failures++; $display("FAIL sat_pos got=%h/%b want=7fff/1", acc_data, acc_ovf); end
    issue(M_ADD,  2'b01, 2'd2, 8'h00, 16'hFFFF, 16'h0);
    checks++;
    if (acc_data !== 16'h7FFE || acc_ovf !== 1'b1) begin failures++; $display("FAIL sticky_ovf got=%h/%b want=7ffe/1", acc_data, acc_ovf); end
    issue(M_CLR,  2'b01, 2'd2, 8'h55, 16'h1234, 16'h4321);
    checks++;
    if (acc_data !== 16'h0 || acc_zero !== 1'b1 || acc_ovf !== 1'b0) begin failures++; $display("FAIL clr got=%h/%b/%b want=0000/1/0", acc_data, acc_zero, acc_ovf); end
    idle(1);
  endtask

  task automatic test_sat_neg();
    issue(M_LOAD, 2'b10, 2'd0, 8'h00, 16'h0, 16'h8005);
    issue(M_SUB,  2'b01, 2'd0, 8'h00, 16'h0010, 16'h0);
    checks++;
    if (acc_data !== 16'h8000 || acc_ovf !== 1'b1) begin failures++; $display("FAIL sat_neg got=%h/%b want=8000/1", acc_data, acc_ovf); end
    issue(M_LOAD, 2'b00, 2'd0, 8'h01, 16'h0, 16'h0);
    checks++;
    if (acc_data !== 16'h0001 || acc_ovf !== 1'b0) begin failures++; $display("FAIL load_clears_ovf got=%h/%b want=0001/0", acc_data, acc_ovf); end
    idle(1);
  endtask

  task automatic test_read_during_write();
    exp_t e;
    issue(M_LOAD, 2'b01, 2'd3, 8'h00, 16'h1234, 16'h0);
    @(negedge clk);
    loadacc = 1'b1; mode = M_ADD; selacc = 2'b00; wr_sel = 2'd3; immediate = 8'h05; rd_sel = 2'd3;
    #1;
    checks++;
    if (acc_data !== 16'h1234) begin failures++; $display("FAIL rdw_old got=%h want=1234", acc_data); end
    model_apply(M_ADD, 2'b00, 2'd3, 8'h05, rd_data, res_out);
    e.idx = 2'd3; e.acc = mdl_acc[3]; e.ovf = mdl_ovf[3];
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (acc_data !== e.acc || acc_data !== 16'h1239) begin failures++; $display("FAIL rdw_new got=%h want=%h", acc_data, e.acc); end
    @(negedge clk); loadacc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (acc_data !== mdl_acc[i]) begin failures++; $display("FAIL rdw_other acc%0d got=%h want=%h", i, acc_data, mdl_acc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    issue(M_LOAD, 2'b00, 2'd1, 8'h10, 16'h0, 16'h0);
    issue(M_ADD,  2'b00, 2'd1, 8'h20, 16'h0, 16'h0);
    issue(M_ADD,  2'b00, 2'd1, 8'h7F, 16'h0, 16'h0);
    issue(M_SUB,  2'b00, 2'd1, 8'h80, 16'h0, 16'h0);
    issue(M_ADD,  2'b01, 2'd1, 8'h00, 16'h7F00, 16'h0);
    issue(M_SUB,  2'b10, 2'd1, 8'h00, 16'h0, 16'hFFFF);
    for (int k = 0; k < 24; k++)
      issue(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
            8'($urandom), 16'($urandom), 16'($urandom));
    idle(2);
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    rstn = 1'b1; loadacc = 1'b1; mode = M_ADD; selacc = 2'b00; wr_sel = 2'd1; immediate = 8'h05;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (op_done !== 1'b0) begin failures++; $display("FAIL rst_ovr_op_done got=%b want=0", op_done); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      checks++;
      if (acc_data !== 16'h0 || acc_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovr_acc%0d got=%h/%b want=0000/0", i, acc_data, acc_ovf); end
    end
    @(negedge clk); rstn = 1'b0; loadacc = 1'b0;
    issue(M_LOAD, 2'b00, 2'd2, 8'h42, 16'h0, 16'h0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_imm();
    test_sat_pos();
    test_sat_neg();
    test_read_during_write();
    test_back_to_back();
    test_reset_override();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
